// File: rtl/serial_subtractor_16bit.sv
// serial_subtractor_16bit: chunk-serial a - b - borrow_in with a start/done handshake.
// Subtraction is done as a + ~b + ~borrow_in, CHUNK bits per clock, LSB chunk first.
module serial_subtractor_16bit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("CHUNK must divide WIDTH evenly");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_nb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_a_msb;
  logic             r_b_msb;
  logic [CW-1:0]    r_cnt;

  logic [CHUNK:0]   w_sum;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;
  logic             w_accept;

  always_comb begin
    w_sum      = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_nb[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
    w_res_next = WIDTH'({w_sum[CHUNK-1:0], r_res} >> CHUNK);
    w_last     = r_cnt == CW'(N - 1);
    w_accept   = start && r_state != CALC;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_nb       <= '0;
      r_res      <= '0;
      r_carry    <= 1'b0;
      r_a_msb    <= 1'b0;
      r_b_msb    <= 1'b0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      difference <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (r_state == CALC) begin
      r_res   <= w_res_next;
      r_carry <= w_sum[CHUNK];
      r_a     <= r_a >> CHUNK;
      r_nb    <= r_nb >> CHUNK;
      r_cnt   <= r_cnt + CW'(1);
      done    <= w_last;
      busy    <= !w_last;
      if (w_last) begin
        r_state    <= DONE;
        difference <= w_res_next;
        borrow_out <= ~w_sum[CHUNK];
        overflow   <= (r_a_msb ^ r_b_msb) & (w_res_next[WIDTH-1] ^ r_a_msb);
      end
    end else begin
      done <= 1'b0;
      busy <= w_accept;
      if (w_accept) begin
        assert (!$isunknown({a, b, borrow_in}))
          else $error("Inputs to serial subtractor were incorrect.");
        r_state <= CALC;
        r_a     <= a;
        r_nb    <= ~b;
        r_carry <= ~borrow_in;
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
        r_cnt   <= '0;
      end else begin
        r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// tb_serial_subtractor_16bit: directed and random checks of the serial subtractor against an arithmetic model.
module tb_serial_subtractor_16bit;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        borrow_in = 1'b0;
  logic        busy, done, borrow_out, overflow;
  logic [15:0] difference;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc, bcnt, dcnt;
  logic [15:0] seen;

  serial_subtractor_16bit dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .difference(difference), .borrow_out(borrow_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {overflow, borrow_out, difference} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_, input logic tbi);
    int          sa, sb, sd;
    logic [15:0] d;
    d  = 16'((int'(ta) - int'(tb_) - int'(tbi)) & 'hFFFF);
    sa = int'($signed(ta));
    sb = int'($signed(tb_));
    sd = sa - sb - int'(tbi);
    return {(sd > 32767 || sd < -32768), (int'(ta) < int'(tb_) + int'(tbi)), d};
  endfunction

  // Starting one negedge after the accepting edge, wait for done; cyc = edges since acceptance.
  task automatic wait_done();
    cyc = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      bcnt += int'(busy);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbi, input string tag);
    logic [17:0] e;
    e = model(ta, tb_, tbi);
    @(negedge clk);
    a = ta; b = tb_; borrow_in = tbi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
    wait_done();
    chk({tag, "_lat"}, cyc, 4);
    chk({tag, "_busy"}, bcnt, 4);
    chk({tag, "_res"}, {14'b0, overflow, borrow_out, difference}, {14'b0, e});
  endtask

  initial begin
    #1;
    chk("rst_out", {busy, done, borrow_out, overflow, difference}, 0);
    @(negedge clk);
    n_rst = 1'b1;

    op(16'h0005, 16'h0003, 1'b0, "t1");
    chk("t1_lit", {overflow, borrow_out, difference}, {2'b00, 16'h0002});
    @(negedge clk);
    chk("t1_done_pulse", done, 0);

    op(16'h0000, 16'h0001, 1'b0, "t2a");
    chk("t2a_lit", {overflow, borrow_out, difference}, {2'b01, 16'hFFFF});
    op(16'h8000, 16'h0001, 1'b0, "t2b");
    chk("t2b_lit", {overflow, borrow_out, difference}, {2'b10, 16'h7FFF});
    op(16'h7FFF, 16'hFFFF, 1'b0, "t3a");
    chk("t3a_lit", {overflow, borrow_out, difference}, {2'b11, 16'h8000});
    op(16'h1234, 16'h1234, 1'b1, "t3b");
    chk("t3b_lit", {overflow, borrow_out, difference}, {2'b01, 16'hFFFF});

    @(negedge clk);
    a = 16'h00FF; b = 16'h000F; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'h1111; b = 16'h0101;
    @(negedge clk);
    start = 1'b0;
    dcnt = 0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      if (done) begin dcnt++; seen = difference; end
      @(negedge clk);
    end
    chk("t4_dones", dcnt, 1);
    chk("t4_diff", seen, 16'h00F0);

    op(16'h0005, 16'h0003, 1'b0, "t5a");
    a = 16'h0010; b = 16'h0020; borrow_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_no_idle", busy, 1);
    chk("t5_hold", difference, 16'h0002);
    wait_done();
    chk("t5_lat", cyc, 4);
    chk("t5_res", {borrow_out, difference}, {1'b1, 16'hFFF0});

    @(negedge clk);
    a = 16'h1234; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b0;
    #1 chk("t6_rst_out", {busy, done, borrow_out, overflow, difference}, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      dcnt += int'(done);
      @(negedge clk);
    end
    chk("t6_no_done", dcnt, 0);
    op(16'hABCD, 16'h0BCD, 1'b0, "t6");
    chk("t6_lit", {overflow, borrow_out, difference}, {2'b00, 16'hA000});

    for (int i = 0; i < 1000; i++)
      op(16'($urandom), 16'($urandom), 1'($urandom), "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
